// File: rtl/vmem_fill_pkg.sv
// rtl/vmem_fill_pkg.sv - shared constants and FSM state type for the vmem rectangle-fill engine
package vmem_fill_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_ORIGIN = 4'h4;
  localparam logic [3:0] REG_SIZE   = 4'h8;
  localparam logic [3:0] REG_COLOR  = 4'hC;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int DEF_SCREEN_W = 240;
  localparam int DEF_SCREEN_H = 240;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } fill_state_e;

endpackage

// File: rtl/vmem_wr_arb.sv
// rtl/vmem_wr_arb.sv - fixed-priority vmem write mux (CPU over engine) with registered write port
module vmem_wr_arb (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_waddr_i,
  input  logic [2:0]  cpu_wdata_i,
  input  logic        eng_req_i,
  input  logic [15:0] eng_waddr_i,
  input  logic [2:0]  eng_wdata_i,
  output logic        eng_gnt_o,
  output logic        vmem_we_o,
  output logic [15:0] vmem_waddr_o,
  output logic [2:0]  vmem_wdata_o
);

  assign eng_gnt_o = eng_req_i && !cpu_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vmem_we_o    <= 1'b0;
      vmem_waddr_o <= '0;
      vmem_wdata_o <= '0;
    end else begin
      vmem_we_o    <= cpu_we_i || eng_req_i;
      vmem_waddr_o <= cpu_we_i ? cpu_waddr_i : eng_waddr_i;
      vmem_wdata_o <= cpu_we_i ? cpu_wdata_i : eng_wdata_i;
    end
  end

endmodule

// File: rtl/vmem_fill_ctrl.sv
// rtl/vmem_fill_ctrl.sv - memory-mapped rectangle-fill engine merged with CPU pixel stores
module vmem_fill_ctrl
  import vmem_fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_waddr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_waddr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  fill_state_e r_state, w_state_nxt;

  logic [7:0] r_cfg_x0, r_cfg_y0, r_cfg_w, r_cfg_h;
  logic [2:0] r_cfg_color;
  logic [7:0] r_x0, r_y0, r_w, r_h, r_cur_x, r_cur_y;
  logic [2:0] r_color;
  logic [8:0] r_x_end, r_y_end;
  logic       r_done_flag, r_busy, r_done;
  logic [31:0] r_rdata;

  logic       w_ctrl_wr, w_start, w_abort, w_start_ok;
  logic       w_eng_req, w_eng_gnt, w_last, w_empty;
  logic [8:0] w_x_sum, w_y_sum, w_x_lim, w_y_lim;
  logic       w_unused_wdata;

  assign w_unused_wdata = ^cfg_wdata_i[31:16];

  assign w_ctrl_wr  = cfg_we_i && (cfg_addr_i == REG_CTRL);
  assign w_start    = w_ctrl_wr && cfg_wdata_i[CTRL_START_BIT];
  assign w_abort    = w_ctrl_wr && cfg_wdata_i[CTRL_ABORT_BIT];
  assign w_start_ok = w_start && !w_abort && (r_state == ST_IDLE);

  // 9-bit sums so a rectangle running past 255 clips instead of wrapping
  assign w_x_sum = {1'b0, r_x0} + {1'b0, r_w};
  assign w_y_sum = {1'b0, r_y0} + {1'b0, r_h};
  assign w_x_lim = (w_x_sum > W_LIM) ? W_LIM : w_x_sum;
  assign w_y_lim = (w_y_sum > H_LIM) ? H_LIM : w_y_sum;
  assign w_empty = (r_w == 8'd0) || (r_h == 8'd0) ||
                   ({1'b0, r_x0} >= W_LIM) || ({1'b0, r_y0} >= H_LIM);

  assign w_last    = ({1'b0, r_cur_x} == r_x_end) && ({1'b0, r_cur_y} == r_y_end);
  assign w_eng_req = (r_state == ST_FILL) && !w_abort;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_SETUP;
      ST_SETUP: begin
        if (w_abort)      w_state_nxt = ST_IDLE;
        else if (w_empty) w_state_nxt = ST_DONE;
        else              w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_abort)                  w_state_nxt = ST_IDLE;
        else if (w_eng_gnt && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_flag <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
      if (r_state == ST_DONE)       r_done_flag <= 1'b1;
      else if (w_start && !w_abort) r_done_flag <= 1'b0;
      r_rdata <= {30'b0, r_done_flag, r_busy};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg_x0    <= '0;
      r_cfg_y0    <= '0;
      r_cfg_w     <= '0;
      r_cfg_h     <= '0;
      r_cfg_color <= '0;
    end else if (cfg_we_i) begin
      case (cfg_addr_i)
        REG_ORIGIN: begin
          r_cfg_x0 <= cfg_wdata_i[7:0];
          r_cfg_y0 <= cfg_wdata_i[15:8];
        end
        REG_SIZE: begin
          r_cfg_w <= cfg_wdata_i[7:0];
          r_cfg_h <= cfg_wdata_i[15:8];
        end
        REG_COLOR: r_cfg_color <= cfg_wdata_i[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      if (w_start_ok) begin
        r_x0    <= r_cfg_x0;
        r_y0    <= r_cfg_y0;
        r_w     <= r_cfg_w;
        r_h     <= r_cfg_h;
        r_color <= r_cfg_color;
      end
      if (r_state == ST_SETUP) begin
        r_x_end <= w_x_lim - 9'd1;
        r_y_end <= w_y_lim - 9'd1;
        r_cur_x <= r_x0;
        r_cur_y <= r_y0;
      end else if (w_eng_gnt) begin
        if ({1'b0, r_cur_x} == r_x_end) begin
          r_cur_x <= r_x0;
          r_cur_y <= r_cur_y + 8'd1;
        end else begin
          r_cur_x <= r_cur_x + 8'd1;
        end
      end
    end
  end

  vmem_wr_arb u_arb (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_we_i     (cpu_we_i),
    .cpu_waddr_i  (cpu_waddr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .eng_req_i    (w_eng_req),
    .eng_waddr_i  ({r_cur_y, r_cur_x}),
    .eng_wdata_i  (r_color),
    .eng_gnt_o    (w_eng_gnt),
    .vmem_we_o    (vmem_we_o),
    .vmem_waddr_o (vmem_waddr_o),
    .vmem_wdata_o (vmem_wdata_o)
  );

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign cfg_rdata_o = r_rdata;

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// tb/tb_vmem_fill_ctrl.sv - scoreboard bench for vmem_fill_ctrl with a pixel-list reference model
module tb_vmem_fill_ctrl;
  import vmem_fill_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        cpu_we_i = 1'b0;
  logic [15:0] cpu_waddr_i = '0;
  logic [2:0]  cpu_wdata_i = '0;
  logic        vmem_we_o;
  logic [15:0] vmem_waddr_o;
  logic [2:0]  vmem_wdata_o;
  logic        busy_o;
  logic        done_o;

  vmem_fill_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rdata_o  (cfg_rdata_o),
    .cpu_we_i     (cpu_we_i),
    .cpu_waddr_i  (cpu_waddr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .vmem_we_o    (vmem_we_o),
    .vmem_waddr_o (vmem_waddr_o),
    .vmem_wdata_o (vmem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int fill_seen = 0;
  logic mon_cpu;
  logic [18:0] q_fill[$];
  logic [18:0] q_cpu[$];
  int m_x0 = 0, m_y0 = 0, m_w = 0, m_h = 0, m_col = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // CPU stores are forwarded in the cycle after they are driven; everything else must be the next fill pixel
  always @(posedge clk_i) begin
    cyc++;
    mon_cpu = cpu_we_i;
    #1;
    if (rst_ni) begin
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (mon_cpu) begin
        if (q_cpu.size() == 0) flag("cpu_queue_empty", {13'b0, vmem_waddr_o, vmem_wdata_o});
        else chk("cpu_fwd", {12'b0, vmem_we_o, vmem_waddr_o, vmem_wdata_o}, {13'b1, q_cpu.pop_front()});
      end else if (vmem_we_o) begin
        if (q_fill.size() == 0) flag("extra_fill_write", {13'b0, vmem_waddr_o, vmem_wdata_o});
        else chk("fill_pixel", {13'b0, vmem_waddr_o, vmem_wdata_o}, {13'b0, q_fill.pop_front()});
        fill_seen++;
      end
    end
  end

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    cfg_we_i = 1'b1;
    cfg_addr_i = a;
    cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    if (a == REG_ORIGIN) begin m_x0 = int'(d[7:0]); m_y0 = int'(d[15:8]); end
    if (a == REG_SIZE)   begin m_w  = int'(d[7:0]); m_h  = int'(d[15:8]); end
    if (a == REG_COLOR)  m_col = int'(d[2:0]);
  endtask

  task automatic model_push(input int limit, output int n);
    logic [7:0] xb, yb;
    logic [2:0] cb;
    n = 0;
    cb = m_col[2:0];
    for (int y = m_y0; y < m_y0 + m_h && y < DEF_SCREEN_H; y++)
      for (int x = m_x0; x < m_x0 + m_w && x < DEF_SCREEN_W; x++)
        if (n < limit) begin
          xb = x[7:0];
          yb = y[7:0];
          q_fill.push_back({yb, xb, cb});
          n++;
        end
  endtask

  task automatic do_start(input int limit, output int t0, output int n);
    model_push(limit, n);
    t0 = cyc + 1;
    cfg_wr(REG_CTRL, 32'h1);
  endtask

  task automatic setup(input logic [31:0] org, input logic [31:0] sz, input logic [31:0] col);
    cfg_wr(REG_ORIGIN, org);
    cfg_wr(REG_SIZE, sz);
    cfg_wr(REG_COLOR, col);
  endtask

  task automatic wait_done(input string name, input int budget, input bit noise,
                           input int t0, input int exp_lat);
    int c0;
    int i;
    logic [15:0] a;
    logic [2:0] dd;
    c0 = done_cnt;
    i = 0;
    while (done_cnt == c0 && i < budget) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        a = 16'($urandom);
        dd = 3'($urandom);
        cpu_we_i = 1'b1;
        cpu_waddr_i = a;
        cpu_wdata_i = dd;
        q_cpu.push_back({a, dd});
      end else begin
        cpu_we_i = 1'b0;
      end
      @(negedge clk_i);
      i++;
    end
    cpu_we_i = 1'b0;
    if (done_cnt == c0) flag({name, "_timeout"}, 32'(i));
    else if (exp_lat >= 0) chk({name, "_latency"}, 32'(last_done_cyc - t0), 32'(exp_lat));
  endtask

  task automatic wait_fill(input int base, input int cnt);
    int i;
    i = 0;
    while (fill_seen - base < cnt && i < 500) begin
      @(negedge clk_i);
      i++;
    end
    if (fill_seen - base < cnt) flag("wait_fill_timeout", 32'(fill_seen - base));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    int t0, n, base, c0;
    repeat (3) @(negedge clk_i);
    chk("rst_vmem_we", {31'b0, vmem_we_o}, 0);
    chk("rst_vmem_waddr", {16'b0, vmem_waddr_o}, 0);
    chk("rst_vmem_wdata", {29'b0, vmem_wdata_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_rdata", cfg_rdata_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_rdata", cfg_rdata_o, 0);

    setup(32'h0000, 32'hF0F0, 32'h0);
    do_start(1 << 30, t0, n);
    wait_done("full_clear", 60000, 1'b0, t0, 57602);
    chk("full_clear_drain", 32'(q_fill.size()), 0);
    @(negedge clk_i);
    chk("status_done_flag", cfg_rdata_o, 32'h2);

    setup(32'hEEEE, 32'h0505, 32'h5);
    do_start(1 << 30, t0, n);
    wait_done("clip", 100, 1'b0, t0, 6);
    chk("clip_drain", 32'(q_fill.size()), 0);

    setup(32'h140A, 32'h0104, 32'h3);
    do_start(1 << 30, t0, n);
    repeat (2) @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      cpu_we_i = 1'b1;
      cpu_waddr_i = 16'h1234 + 16'(k);
      cpu_wdata_i = 3'(k + 1);
      q_cpu.push_back({cpu_waddr_i, cpu_wdata_i});
      @(negedge clk_i);
    end
    cpu_we_i = 1'b0;
    wait_done("contention", 100, 1'b0, t0, 9);
    chk("contention_drain", 32'(q_fill.size() + q_cpu.size()), 0);

    cfg_wr(REG_SIZE, 32'h0500);
    do_start(1 << 30, t0, n);
    wait_done("degen_h0", 50, 1'b0, t0, 2);
    setup(32'hF000, 32'h0505, 32'h1);
    do_start(1 << 30, t0, n);
    wait_done("degen_y0", 50, 1'b0, t0, 2);

    setup(32'h0505, 32'h0A0A, 32'h6);
    base = fill_seen;
    c0 = done_cnt;
    do_start(10, t0, n);
    wait_fill(base, 10);
    cfg_wr(REG_CTRL, 32'h2);
    repeat (20) @(negedge clk_i);
    chk("abort_drain", 32'(q_fill.size()), 0);
    chk("abort_no_done", 32'(done_cnt), 32'(c0));
    chk("abort_status", cfg_rdata_o, 0);
    do_start(1 << 30, t0, n);
    wait_done("after_abort", 300, 1'b0, t0, 102);
    chk("after_abort_drain", 32'(q_fill.size()), 0);

    setup(32'h3020, 32'h0405, 32'h1);
    do_start(1 << 30, t0, n);
    repeat (4) @(negedge clk_i);
    cfg_wr(REG_ORIGIN, 32'h6050);
    cfg_wr(REG_CTRL, 32'h1);
    wait_done("restart_ignored", 100, 1'b0, t0, 22);
    repeat (10) @(negedge clk_i);
    chk("restart_drain", 32'(q_fill.size()), 0);
    do_start(1 << 30, t0, n);
    wait_done("next_fill_new_origin", 100, 1'b0, t0, 22);

    for (int it = 0; it < 8; it++) begin
      setup({16'b0, 8'($urandom_range(0, 250)), 8'($urandom_range(0, 250))},
            {16'b0, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))},
            32'($urandom_range(0, 7)));
      do_start(1 << 30, t0, n);
      wait_done("random_fill", 2000, 1'b1, t0, -1);
      repeat (2) @(negedge clk_i);
      chk("random_drain", 32'(q_fill.size() + q_cpu.size()), 0);
    end

    setup(32'h1010, 32'h0A05, 32'h7);
    base = fill_seen;
    do_start(1 << 30, t0, n);
    wait_fill(base, 5);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_we", {31'b0, vmem_we_o}, 0);
    chk("async_rst_waddr", {16'b0, vmem_waddr_o}, 0);
    chk("async_rst_busy", {31'b0, busy_o}, 0);
    chk("async_rst_rdata", cfg_rdata_o, 0);
    q_fill.delete();
    c0 = done_cnt;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("post_rst_idle_busy", {31'b0, busy_o}, 0);
    chk("post_rst_no_done", 32'(done_cnt), 32'(c0));
    setup(32'h0203, 32'h0103, 32'h4);
    do_start(1 << 30, t0, n);
    wait_done("post_rst_fill", 50, 1'b0, t0, 5);

    repeat (5) @(negedge clk_i);
    chk("final_fill_queue", 32'(q_fill.size()), 0);
    chk("final_cpu_queue", 32'(q_cpu.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vmem_fill_ctrl.md
# vmem_fill_ctrl

Memory-mapped rectangle-fill engine and write-port arbiter for the 240x240, 3-bit-per-pixel video memory. Sits between the data bus and the vmem write port. Merges CPU pixel stores with hardware-generated fill writes so the CPU can clear or paint regions without a store per pixel. CPU stores always win. The engine stalls, never drops, a pixel.

## Interface
Parameters:
- `SCREEN_W`, default 240: pixels per row. The x-clip bound.
- `SCREEN_H`, default 240: rows. The y-clip bound.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `cfg_we_i`, in, 1: register write strobe (already address-decoded).
- `cfg_addr_i`, in, 4: byte offset. 0x0 CTRL, 0x4 ORIGIN, 0x8 SIZE, 0xC COLOR.
- `cfg_wdata_i`, in, 32: register write data.
- `cfg_rdata_o`, out, 32: status `{30'b0, done_flag, busy}`, registered.
- `cpu_we_i`, in, 1: CPU pixel store request.
- `cpu_waddr_i`, in, 16: CPU pixel address `{y, x}`.
- `cpu_wdata_i`, in, 3: CPU pixel colour.
- `vmem_we_o`, out, 1: vmem write enable.
- `vmem_waddr_o`, out, 16: vmem write address.
- `vmem_wdata_o`, out, 3: vmem write data.
- `busy_o`, out, 1: fill in progress.
- `done_o`, out, 1: one-cycle pulse when a fill completes normally.

## Operation
Registers:
- ORIGIN: `[7:0]` x0, `[15:8]` y0.
- SIZE: `[7:0]` w, `[15:8]` h. Unit is pixels; 0 means empty.
- COLOR: `[2:0]`.
- CTRL: bit0 start, bit1 abort. Write-only pulses.

Register behaviour:
- Writes to ORIGIN, SIZE and COLOR are accepted at any time.
- START latches them into working registers. Writes made mid-fill affect only the next fill.

FSM states: IDLE, SETUP, FILL, DONE.
- **IDLE**: start goes to SETUP. Abort is ignored.
- **SETUP** (1 cycle), computing the clipped rectangle:
  - x_end = min(x0 + w, SCREEN_W) - 1
  - y_end = min(y0 + h, SCREEN_H) - 1
  - Use 9-bit sums, no wrap.
  - If w==0, h==0, x0≥SCREEN_W or y0≥SCREEN_H, go to DONE with zero writes.
  - Otherwise go to FILL with cur = (x0, y0).
- **FILL**, each cycle:
  - If `cpu_we_i`=0, issue pixel (cur_x, cur_y) and advance row-major: x increments; at x_end, x returns to x0 and y increments.
  - If `cpu_we_i`=1, forward the CPU store and hold cur.
  - Issuing (x_end, y_end) goes to DONE.
- **DONE** (1 cycle): pulse `done_o`, set `done_flag`, go to IDLE.

Control events:
- Start while not IDLE is ignored.
- Abort in SETUP or FILL goes to IDLE immediately: no further engine writes, no `done_o`, `done_flag` unchanged.
- Abort and start written in the same cycle: abort wins.
- A write with start=1 clears `done_flag`.

Arbitration and addressing:
- The arbiter grants the CPU whenever `cpu_we_i`=1, in any state.
- Pixel address is `{y[7:0], x[7:0]}`.

Reset: async assertion returns to IDLE mid-fill; the fill is lost. Values:
- outputs: `vmem_*_o`=0, `busy_o`=0, `done_o`=0, `cfg_rdata_o`=0;
- all config/working regs and `done_flag`: 0.

## Timing
- All outputs are registered.
- The vmem write port sees a write one cycle after the grant decision.
- Start written on edge T:
  - state is SETUP after T and FILL after T+1;
  - the first fill write is on `vmem_we_o` after edge T+2.
- Uncontended fill of N pixels:
  - last write after edge T+N+1;
  - `done_o` high for the cycle after edge T+N+2;
  - `busy_o` high after T through the cycle of the last write.
- Each CPU store adds exactly one cycle.
- CPU-store latency is 1 cycle (`cpu_*` to `vmem_*_o`) in every state.
- `cfg_rdata_o` reflects status with 1-cycle latency.

## Structure
- Package `vmem_fill_pkg`: register offsets (CTRL/ORIGIN/SIZE/COLOR), CTRL bit indices, FSM state enum, default SCREEN_W/H.
- One sub-module, `vmem_wr_arb`: fixed-priority two-requester write mux plus output register. It owns `vmem_*_o` and reports a grant back so the FSM holds cur.
- The FSM, clip arithmetic and registers live in the top.

## Test plan
- **Full clear**: ORIGIN=0, SIZE=0xF0F0, COLOR=0, start.
  - Expect exactly 57600 writes, addresses 0x0000..0xEFEF row-major, skipping x≥240.
  - `done_o` 57602 cycles after start.
- **Clip**: ORIGIN=0xEEEE, SIZE=0x0505, COLOR=5.
  - Expect 4 writes: 0xEEEE, 0xEEEF, 0xEFEE, 0xEFEF, each with data 5.
- **Contention**: 4x1 fill at (10,20) with `cpu_we_i` held for 3 cycles mid-fill.
  - Expect CPU writes passed unchanged, no fill pixel lost or repeated.
  - `done_o` 3 cycles later than uncontended.
- **Degenerate start**: SIZE=0x0500.
  - Expect zero writes and `done_o` 2 cycles after start.
  - ORIGIN=0xF000 also gives zero writes.
- **Abort**: abort after 10 of 100 pixels.
  - Expect no further engine writes and no `done_o`.
  - A subsequent start runs the full fill.
- **Restart and reset**: start during FILL is ignored (write count unchanged).
  - `rst_ni` low mid-fill: outputs 0 asynchronously, FSM IDLE on release.
